csr_file: RTL
=============

# csr_file

Machine-mode control and status register file, the responder for the committer's CSR write interface (`csr_wif`) and the source of `csr_rdata` for the dispatcher's register-read stage. It holds the M-mode trap CSRs and the 64-bit cycle/instret counters. It applies CSR writes and trap entry on the cycle after a valid request, and exports `mtvec`/`mepc` to the system unit for redirect targets.

## Interface
Parameters:
- `RESET_MTVEC`, `'0`: reset value of `mtvec` (XLEN bits; mode field must be 0 or 1).
- `HART_ID`, `0`: value returned by `mhartid`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `wbcsr_wif`  csr_wif.rsp  —  write request from the committer. Fields:
  - `addr` 12
  - `data` XLEN
  - `pc` XLEN
  - `cause` XLEN
  - `trap` 1
  - `valid` 1
- `rd_addr`  in  12  read address from the register-read stage.
- `rd_data`  out  XLEN  read data, combinational.
- `rd_illegal`  out  1  `rd_addr` is not implemented (combinational).
- `retire`  in  1  one instruction committed this cycle (the committer's `wbrf` handshake).
- `mtvec_o`  out  XLEN  trap vector base for the system unit.
- `mepc_o`  out  XLEN  current `mepc`.
- `mie_o`  out  1  `mstatus.MIE`.

## Operation
Implemented CSRs (all others: `rd_illegal=1`, `rd_data=0`, writes ignored):
- `mstatus` 0x300:
  - only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] is hardwired 2'b11.
  - all other bits read 0.
- `misa` 0x301: read-only constant (MXL per XLEN, I bit set); writes ignored.
- `mtvec` 0x305: WARL.
  - A written mode of 2 or 3 stores mode 0; the base is stored as written.
  - Only direct mode affects exceptions.
- `mscratch` 0x340: full read/write.
- `mepc` 0x341: bits [1:0] always 0.
- `mcause` 0x342: full read/write.
- `mtval` 0x343: read/write; trap entry writes 0.
- `mcycle` 0xB00 and `minstret` 0xB02: low 32 bits for XLEN=32, full 64 bits for XLEN=64.
- `mcycleh` 0xB80 and `minstreth` 0xB82: bits 63:32, XLEN=32 only; illegal for XLEN=64.
- `mhartid` 0xF14: read-only, returns `HART_ID`.

Request handling (`valid=1`):
- `trap=1` performs trap entry and ignores `addr`/`data`:
  - `mepc <= pc & ~3`
  - `mcause <= cause`
  - `mtval <= 0`
  - `MPIE <= MIE`
  - `MIE <= 0`
- `trap=0` writes `data` to `addr` under the rules above.
- `mret` has no dedicated port. The system unit issues it as an `mstatus` write carrying MIE=MPIE, MPIE=1.

Counters:
- `mcycle` increments every cycle.
- `minstret` increments when `retire=1`.
- A software write to either half of a counter in the same cycle wins: that cycle the written half takes `data`, the other half holds, and there is no increment.
- Counters wrap modulo 2^64.

## Timing
- Reset values:
  - `mstatus` reads 0x1800.
  - `mtvec = RESET_MTVEC` with the mode fixed up.
  - `mscratch`, `mepc`, `mcause`, `mtval`, `mcycle`, `minstret` are all 0.
  - Outputs are therefore `mtvec_o=RESET_MTVEC`, `mepc_o=0`, `mie_o=0`.
- Writes and trap entry are visible on `rd_data` and the `*_o` outputs in the cycle after `valid`.
- There is no read bypass: reading the address written in the same cycle returns the old value.
- `rd_data` reads a counter's pre-increment value.
- `rst` asserted together with `valid` means reset wins.

## Structure
- `riscv_pkg` holds:
  - the CSR address constants: `CSR_MSTATUS` … `CSR_MHARTID`
  - the `mstatus` bit positions: `MSTATUS_MIE`, `MSTATUS_MPIE`, `MSTATUS_MPP`
  - the `mtvec` mode encodings
- `offnariscv_pkg` holds `csr_wif` and the `rsp` modport, shared with the committer.
- Sub-module `csr_counter`: a 64-bit counter with increment enable and independent lo/hi write enables. It is instantiated twice, once for `mcycle` and once for `minstret`.

## Test plan
- **Reset:** pulse `rst`, then read each CSR.
  - `mstatus=0x1800`, `mtvec=RESET_MTVEC`, all others 0, `rd_illegal=0`.
  - Reading 0x7C0 gives `rd_illegal=1`, `rd_data=0`.
- **Write then read:**
  - Write `mscratch=0xDEADBEEF`; the same-cycle read returns 0 and the next cycle returns 0xDEADBEEF.
  - Write `mtvec=0x8000_0003`; it reads back 0x8000_0000.
- **Trap entry:**
  - Set MIE=1, then send `trap=1`, `pc=0x8000_0106`, `cause=2`, `addr=0x340`.
  - Next cycle: `mepc=0x8000_0104`, `mcause=2`, `MIE=0`, `MPIE=1`, `mscratch` unchanged.
- **mret emulation:** write `mstatus` with MIE=MPIE, MPIE=1; next cycle `mie_o=1` and MPP still reads 11.
- **Counters (XLEN=32):**
  - Write `mcycle=0xFFFF_FFFF`, `mcycleh=0`; two cycles later `mcycleh=1`.
  - Hold `retire` high for 5 cycles; `minstret` advances by 5.
  - A write coinciding with `retire` takes the written value.
- **Read-only writes:** write `misa` and `mhartid`; values are unchanged and nothing is flagged.

Source files
------------

// File: rtl/riscv_pkg.sv
// RISC-V machine-mode CSR constants shared by the CSR file and its clients.
// XLEN, CSR addresses, mstatus bit positions and mtvec mode encodings.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;  // LSB of the 2-bit MPP field

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    // MXL in the top two bits, extension 'I' at bit 8.
    localparam logic [XLEN-1:0] MISA_VAL =
        {((XLEN == 64) ? 2'd2 : 2'd1), {(XLEN-11){1'b0}}, 1'b1, 8'h00};

    // Reserved modes (2, 3) collapse to direct; the base is kept as written.
    function automatic logic [XLEN-1:0] mtvec_warl(input logic [XLEN-1:0] v);
        return (v[1:0] > MTVEC_VECTORED) ? {v[XLEN-1:2], MTVEC_DIRECT} : v;
    endfunction
endpackage

// File: rtl/csr_wif.sv
// CSR write interface between the committer (req) and the CSR file (rsp).
interface csr_wif;
    import riscv_pkg::*;
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] cause;
    logic            trap;
    logic            valid;

    modport req (output addr, data, pc, cause, trap, valid);
    modport rsp (input  addr, data, pc, cause, trap, valid);
endinterface

// File: rtl/csr_counter.sv
// 64-bit counter with increment enable and independent lo/hi write enables.
// Any write that cycle suppresses the increment; the unwritten half holds.
module csr_counter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata_lo,
    input  logic [31:0] i_wdata_hi,
    output logic [63:0] o_count
);
    logic [63:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_we_lo || i_we_hi) begin
            if (i_we_lo) r_count[31:0]  <= i_wdata_lo;
            if (i_we_hi) r_count[63:32] <= i_wdata_hi;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap CSRs, mcycle/minstret, write/trap port from the
// committer and a combinational read port for the register-read stage.
module csr_file
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic            clk,
    input  logic            rst,
    csr_wif.rsp             wbcsr_wif,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_illegal,
    input  logic            retire,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);
    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic            w_wr, w_trap;
    logic [63:0]     w_cyc, w_ins;
    logic [31:0]     w_wlo, w_whi;
    logic            w_cyc_we_lo, w_cyc_we_hi, w_ins_we_lo, w_ins_we_hi;

    assign w_wr   = wbcsr_wif.valid && !wbcsr_wif.trap;
    assign w_trap = wbcsr_wif.valid &&  wbcsr_wif.trap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= mtvec_warl(RESET_MTVEC);
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (w_trap) begin
            r_mepc   <= {wbcsr_wif.pc[XLEN-1:2], 2'b00};
            r_mcause <= wbcsr_wif.cause;
            r_mtval  <= '0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_wr) begin
            case (wbcsr_wif.addr)
                CSR_MSTATUS: begin
                    r_mie  <= wbcsr_wif.data[MSTATUS_MIE];
                    r_mpie <= wbcsr_wif.data[MSTATUS_MPIE];
                end
                CSR_MTVEC:    r_mtvec    <= mtvec_warl(wbcsr_wif.data);
                CSR_MSCRATCH: r_mscratch <= wbcsr_wif.data;
                CSR_MEPC:     r_mepc     <= {wbcsr_wif.data[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   r_mcause   <= wbcsr_wif.data;
                CSR_MTVAL:    r_mtval    <= wbcsr_wif.data;
                default: ;
            endcase
        end
    end

    // On RV64 the low-address write covers the whole counter; on RV32 the
    // *h address owns the upper word.
    assign w_wlo = wbcsr_wif.data[31:0];
    assign w_whi = (XLEN == 64) ? 32'(64'(wbcsr_wif.data) >> 32) : wbcsr_wif.data[31:0];

    assign w_cyc_we_lo = w_wr && (wbcsr_wif.addr == CSR_MCYCLE);
    assign w_cyc_we_hi = w_wr && ((XLEN == 64) ? (wbcsr_wif.addr == CSR_MCYCLE)
                                               : (wbcsr_wif.addr == CSR_MCYCLEH));
    assign w_ins_we_lo = w_wr && (wbcsr_wif.addr == CSR_MINSTRET);
    assign w_ins_we_hi = w_wr && ((XLEN == 64) ? (wbcsr_wif.addr == CSR_MINSTRET)
                                               : (wbcsr_wif.addr == CSR_MINSTRETH));

    csr_counter u_mcycle (
        .i_clk(clk), .i_rst(rst), .i_inc(1'b1),
        .i_we_lo(w_cyc_we_lo), .i_we_hi(w_cyc_we_hi),
        .i_wdata_lo(w_wlo), .i_wdata_hi(w_whi), .o_count(w_cyc)
    );

    csr_counter u_minstret (
        .i_clk(clk), .i_rst(rst), .i_inc(retire),
        .i_we_lo(w_ins_we_lo), .i_we_hi(w_ins_we_hi),
        .i_wdata_lo(w_wlo), .i_wdata_hi(w_whi), .o_count(w_ins)
    );

    always_comb begin
        rd_data    = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            CSR_MSTATUS: begin
                rd_data[MSTATUS_MIE]      = r_mie;
                rd_data[MSTATUS_MPIE]     = r_mpie;
                rd_data[MSTATUS_MPP +: 2] = 2'b11;
            end
            CSR_MISA:     rd_data = MISA_VAL;
            CSR_MTVEC:    rd_data = r_mtvec;
            CSR_MSCRATCH: rd_data = r_mscratch;
            CSR_MEPC:     rd_data = r_mepc;
            CSR_MCAUSE:   rd_data = r_mcause;
            CSR_MTVAL:    rd_data = r_mtval;
            CSR_MCYCLE:   rd_data = XLEN'(w_cyc);
            CSR_MINSTRET: rd_data = XLEN'(w_ins);
            CSR_MCYCLEH: begin
                if (XLEN == 32) rd_data = XLEN'(w_cyc >> 32);
                else            rd_illegal = 1'b1;
            end
            CSR_MINSTRETH: begin
                if (XLEN == 32) rd_data = XLEN'(w_ins >> 32);
                else            rd_illegal = 1'b1;
            end
            CSR_MHARTID:  rd_data = HART_ID;
            default:      rd_illegal = 1'b1;
        endcase
    end

    assign mtvec_o = r_mtvec;
    assign mepc_o  = r_mepc;
    assign mie_o   = r_mie;
endmodule
